// File: rtl/if_stage_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package if_stage_fetch_pkg;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] NOP     = 32'h0000_0000;
  localparam logic [WIDTH-1:0] PC_STEP = 32'h0000_0004;

  function automatic logic [WIDTH-1:0] word_align(input logic [WIDTH-1:0] addr);
    return {addr[WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_fetch_chk.sv
// Protocol and bookkeeping assertions for the fetch front end.
module if_stage_fetch_chk #(
  parameter int CW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          imem_rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] pcq_count,
  input logic          pcq_empty,
  input logic          pcq_full,
  input logic          req_fire,
  input logic          buf_full,
  input logic          buf_push,
  input logic          buf_pop
);

  a_rsp_with_outstanding: assert property (@(posedge clk) disable iff (!rst)
    imem_rsp_valid |-> (outstanding != {CW{1'b0}}));

  a_pcq_tracks_outstanding: assert property (@(posedge clk) disable iff (!rst)
    (pcq_count == outstanding) && (pcq_empty == (outstanding == {CW{1'b0}})));

  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(req_fire && pcq_full));

  a_buf_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(buf_push && buf_full && !buf_pop));

endmodule

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO with a combinational head, a flush and push+pop-when-full support.
module fetch_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop && !empty;
  assign push_ok_s = push && (!full || pop_ok_s);
  assign head      = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Pointers and occupancy; flush empties the FIFO in a single edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/if_stage_fetch.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word requests and
// presents buffered {pc, instr} pairs to decode, with redirect and stall handling.
module if_stage_fetch
  import if_stage_fetch_pkg::*;
#(
  parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter int               BUF_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_fetch,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic [WIDTH-1:0] pc_fetch,
  output logic [WIDTH-1:0] instr_fetch,
  output logic             fetch_empty
);

  localparam int CW = $clog2(BUF_DEPTH + 1);

  logic [WIDTH-1:0]   pc_r;
  logic [CW-1:0]      outstanding_r;
  logic [CW-1:0]      discard_r;
  logic [CW-1:0]      buffered_s;
  logic [CW-1:0]      credits_s;
  logic [CW-1:0]      pcq_count_s;
  logic [WIDTH-1:0]   rsp_pc_s;
  logic [2*WIDTH-1:0] buf_head_s;
  logic               req_fire_s;
  logic               rsp_fire_s;
  logic               drop_s;
  logic               buf_push_s;
  logic               buf_pop_s;
  logic               buf_empty_s;
  logic               buf_full_s;
  logic               pcq_empty_s;
  logic               pcq_full_s;

  // Credits cover both in-flight requests and parked words, so responses can never overflow.
  assign credits_s     = CW'(BUF_DEPTH) - (outstanding_r + buffered_s);
  assign imem_req_addr = pc_r;
  assign req_fire_s    = imem_req_valid && imem_req_ready;
  assign rsp_fire_s    = imem_rsp_valid && (outstanding_r != {CW{1'b0}});
  assign drop_s        = rsp_fire_s && (discard_r != {CW{1'b0}});
  assign buf_push_s    = rsp_fire_s && !drop_s && !redirect_valid;
  assign buf_pop_s     = !stall_fetch && !buf_empty_s && !redirect_valid;

  // Request qualification: withdrawn during reset, redirect, or when out of credits.
  always_comb begin
    imem_req_valid = 1'b0;
    if (rst && !redirect_valid && (credits_s != {CW{1'b0}})) begin
      imem_req_valid = 1'b1;
    end else begin
      imem_req_valid = 1'b0;
    end
  end

  // Program counter: redirect wins, otherwise advance once per accepted request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_valid) begin
      pc_r <= word_align(redirect_pc);
    end else if (req_fire_s) begin
      pc_r <= pc_r + PC_STEP;
    end
  end

  // In-flight request count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      outstanding_r <= {CW{1'b0}};
    end else begin
      case ({req_fire_s, rsp_fire_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1);
        2'b01:   outstanding_r <= outstanding_r - CW'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Responses still owed to the wrong path; a response landing in the redirect cycle is already gone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      discard_r <= {CW{1'b0}};
    end else if (redirect_valid) begin
      discard_r <= outstanding_r + CW'(req_fire_s) - CW'(rsp_fire_s);
    end else if (drop_s) begin
      discard_r <= discard_r - CW'(1);
    end
  end

  // Decode-side view: buffer head, or a zero bubble when nothing is buffered.
  always_comb begin
    pc_fetch    = {WIDTH{1'b0}};
    instr_fetch = NOP;
    fetch_empty = 1'b1;
    if (!buf_empty_s) begin
      pc_fetch    = buf_head_s[2*WIDTH-1:WIDTH];
      instr_fetch = buf_head_s[WIDTH-1:0];
      fetch_empty = 1'b0;
    end else begin
      pc_fetch    = {WIDTH{1'b0}};
      instr_fetch = NOP;
      fetch_empty = 1'b1;
    end
  end

  fetch_fifo #(.DW(WIDTH), .DEPTH(BUF_DEPTH)) u_pc_q (
    .clk       (clk),
    .rst       (rst),
    .flush     (1'b0),
    .push      (req_fire_s),
    .push_data (pc_r),
    .pop       (rsp_fire_s),
    .head      (rsp_pc_s),
    .full      (pcq_full_s),
    .empty     (pcq_empty_s),
    .count     (pcq_count_s)
  );

  fetch_fifo #(.DW(2*WIDTH), .DEPTH(BUF_DEPTH)) u_instr_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (buf_push_s),
    .push_data ({rsp_pc_s, imem_rsp_data}),
    .pop       (buf_pop_s),
    .head      (buf_head_s),
    .full      (buf_full_s),
    .empty     (buf_empty_s),
    .count     (buffered_s)
  );

  if_stage_fetch_chk #(.CW(CW)) u_chk (
    .clk            (clk),
    .rst            (rst),
    .imem_rsp_valid (imem_rsp_valid),
    .outstanding    (outstanding_r),
    .pcq_count      (pcq_count_s),
    .pcq_empty      (pcq_empty_s),
    .pcq_full       (pcq_full_s),
    .req_fire       (req_fire_s),
    .buf_full       (buf_full_s),
    .buf_push       (buf_push_s),
    .buf_pop        (buf_pop_s)
  );

endmodule

// File: tb/tb_if_stage_fetch.sv
// Scoreboard bench for if_stage_fetch: expected PC streams are queued by the stimulus,
// a monitor pops and compares every word decode consumes.
module tb_if_stage_fetch;

  localparam int W = 32;
  localparam logic [W-1:0] RPC = 32'h0000_0400;

  logic         clk = 1'b0;
  logic         rst;
  logic         stall_fetch;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         imem_req_valid;
  logic         imem_req_ready;
  logic [W-1:0] imem_req_addr;
  logic         imem_rsp_valid;
  logic [W-1:0] imem_rsp_data;
  logic [W-1:0] pc_fetch;
  logic [W-1:0] instr_fetch;
  logic         fetch_empty;

  int n_checks = 0;
  int n_pass   = 0;
  int consumed = 0;
  int mem_lat  = 1;
  logic [W-1:0] exp_q[$];

  if_stage_fetch #(.RESET_PC(RPC), .BUF_DEPTH(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_fetch    (stall_fetch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .pc_fetch       (pc_fetch),
    .instr_fetch    (instr_fetch),
    .fetch_empty    (fetch_empty)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] imem_word(input logic [W-1:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic load_expected(input logic [W-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic wait_nonempty(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (fetch_empty && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (fetch_empty) begin
      n_checks++;
      $display("FAIL %s: timeout after %0d cycles waiting for a word", name, budget);
    end
  endtask

  // Memory model: fixed-latency, in-order responses, word = imem_word(addr).
  initial begin
    logic         st_v [3];
    logic [W-1:0] st_a [3];
    logic         acc_v;
    logic [W-1:0] acc_a;
    for (int i = 0; i < 3; i++) begin st_v[i] = 1'b0; st_a[i] = 32'h0; end
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc_v = imem_req_valid && imem_req_ready;
      acc_a = imem_req_addr;
      @(posedge clk);
      #1;
      st_v[2] = st_v[1]; st_a[2] = st_a[1];
      st_v[1] = st_v[0]; st_a[1] = st_a[0];
      st_v[0] = acc_v;   st_a[0] = acc_a;
      case (mem_lat)
        1:       begin imem_rsp_valid = st_v[0]; imem_rsp_data = imem_word(st_a[0]); end
        2:       begin imem_rsp_valid = st_v[1]; imem_rsp_data = imem_word(st_a[1]); end
        default: begin imem_rsp_valid = st_v[2]; imem_rsp_data = imem_word(st_a[2]); end
      endcase
    end
  end

  // Monitor: every consumed word must match the scoreboard head; bubbles must be all zero.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (fetch_empty) begin
        check_eq("bubble_pc", pc_fetch, 32'h0);
        check_eq("bubble_instr", instr_fetch, 32'h0);
      end else if (rst && !stall_fetch && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got pc 0x%08h with nothing expected", pc_fetch);
        end else begin
          e = exp_q.pop_front();
          check_eq("sb_pc", pc_fetch, e);
          check_eq("sb_instr", instr_fetch, imem_word(e));
          consumed++;
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    int bubbles;
    int c0;
    int n;
    rst = 1'b0; stall_fetch = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; imem_req_ready = 1'b1;
    load_expected(RPC);

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_empty", 32'(fetch_empty), 32'd1);
    check_eq("rst_instr", instr_fetch, 32'h0);
    check_eq("rst_pc", pc_fetch, 32'h0);
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    check_eq("first_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("first_req_addr", imem_req_addr, 32'h0000_0400);

    // Streaming, 1-cycle memory: no bubbles once warm
    wait_nonempty("warmup", 20);
    bubbles = 0;
    repeat (20) begin @(negedge clk); if (fetch_empty) bubbles++; end
    check_eq("stream_bubbles", 32'(bubbles), 32'd0);

    // Stall until full, then hold for 3 cycles
    @(posedge clk); #1; stall_fetch = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("stall_hold_pc", pc_fetch, exp_q[0]);
      check_eq("stall_hold_instr", instr_fetch, imem_word(exp_q[0]));
      check_eq("stall_no_req", 32'(imem_req_valid), 32'd0);
    end
    @(posedge clk); #1; stall_fetch = 1'b0;
    repeat (12) @(negedge clk);

    // Redirect flushes a full buffer, then drop two in-flight responses
    @(posedge clk); #1; stall_fetch = 1'b1;
    repeat (6) @(negedge clk);
    mem_lat = 3;
    check_eq("pre_flush_full", 32'(fetch_empty), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0802; load_expected(32'h0000_0800);
    @(negedge clk);
    check_eq("redir_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_empty", 32'(fetch_empty), 32'd1);
    check_eq("redir_req_valid", 32'(imem_req_valid), 32'd1);
    check_eq("redir_req_addr", imem_req_addr, 32'h0000_0800);
    @(posedge clk); #1;
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_1002; stall_fetch = 1'b0;
    load_expected(32'h0000_1000);
    @(negedge clk);
    check_eq("redir2_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    @(negedge clk);
    check_eq("redir2_req_addr", imem_req_addr, 32'h0000_1000);
    wait_nonempty("redir2_fill", 20);
    check_eq("redir2_first_pc", pc_fetch, 32'h0000_1000);
    repeat (10) @(negedge clk);

    // Memory not ready: address stable, redirect retargets next cycle
    @(posedge clk); #1; imem_req_ready = 1'b0;
    repeat (5) @(negedge clk);
    @(negedge clk);
    held = imem_req_addr;
    check_eq("notready_valid", 32'(imem_req_valid), 32'd1);
    check_eq("notready_align", 32'(held[1:0]), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("notready_addr_stable", imem_req_addr, held);
      check_eq("notready_valid_hold", 32'(imem_req_valid), 32'd1);
    end
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000; load_expected(32'h0000_3000);
    @(negedge clk);
    check_eq("notready_redir_no_req", 32'(imem_req_valid), 32'd0);
    @(posedge clk); #1; redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("notready_target_addr", imem_req_addr, 32'h0000_3000);
      check_eq("notready_target_valid", 32'(imem_req_valid), 32'd1);
    end

    // PC wrap at the top of the address space
    @(posedge clk); #1;
    mem_lat = 1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFA; load_expected(32'hFFFF_FFF8);
    @(posedge clk); #1; redirect_valid = 1'b0; imem_req_ready = 1'b1;
    c0 = consumed;
    n = 0;
    @(negedge clk);
    while (!(imem_req_valid && imem_req_addr == 32'hFFFF_FFFC) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("wrap_pre_addr", imem_req_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check_eq("wrap_addr", imem_req_addr, 32'h0000_0000);
    check_eq("wrap_valid", 32'(imem_req_valid), 32'd1);
    repeat (15) @(negedge clk);
    check_eq("wrap_progress", 32'((consumed - c0) >= 8), 32'd1);

    @(posedge clk); #1; imem_req_ready = 1'b0;
    repeat (8) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
